// File: rtl/gzip_stream_sequencer.sv
// Drives the word_merge64 bit packer for one GZIP member at a time: header, fixed-Huffman
// block header, encoder codes, end-of-block, byte-alignment padding and CRC32/ISIZE trailer.
module gzip_stream_sequencer #(
    parameter int          CODE_W  = 32,
    parameter logic [7:0]  OS_BYTE = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_data,
    input  logic [5:0]        code_size,
    input  logic              code_last,
    input  logic              trl_valid,
    output logic              trl_ready,
    input  logic [31:0]       trl_crc,
    input  logic [31:0]       trl_isize,
    output logic              m_valid,
    output logic              m_last,
    output logic [6:0]        m_size,
    output logic [63:0]       m_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_BHDR,
        S_CODE,
        S_EOB,
        S_PAD,
        S_TRL
    } state_t;

    localparam logic [63:0] HDR0_WORD = 64'h0000_0000_0008_8B1F;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [6:0]  m_size_q, m_size_d;
    logic [63:0] m_data_q, m_data_d;

    logic [63:0] code_ext;
    logic [63:0] code_mask;
    logic [2:0]  pad_bits;

    // Bits at or above code_size are don't-care on the encoder bus; the packer needs zeros there.
    assign code_ext  = 64'(code_data);
    assign code_mask = (64'd1 << code_size) - 64'd1;
    assign pad_bits  = 3'd0 - phase_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = 1'b0;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_size_d  = 7'd0;
        m_data_d  = 64'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR0;
                    busy_d  = 1'b1;
                end
            end
            S_HDR0: begin
                m_valid_d = 1'b1;
                m_size_d  = 7'd64;
                m_data_d  = HDR0_WORD;
                state_d   = S_HDR1;
            end
            S_HDR1: begin
                m_valid_d = 1'b1;
                m_size_d  = 7'd16;
                m_data_d  = {48'd0, OS_BYTE, 8'h00};
                state_d   = S_BHDR;
            end
            S_BHDR: begin
                m_valid_d = 1'b1;
                m_size_d  = 7'd3;
                m_data_d  = 64'd3;
                state_d   = S_CODE;
            end
            S_CODE: begin
                if (code_valid) begin
                    // Zero-length codes are consumed silently; the packer requires size >= 1.
                    if (code_size != 6'd0) begin
                        m_valid_d = 1'b1;
                        m_size_d  = {1'b0, code_size};
                        m_data_d  = code_ext & code_mask;
                    end
                    if (code_last) begin
                        state_d = S_EOB;
                    end
                end
            end
            S_EOB: begin
                m_valid_d = 1'b1;
                m_size_d  = 7'd7;
                m_data_d  = 64'd0;
                state_d   = S_PAD;
            end
            S_PAD: begin
                if (pad_bits != 3'd0) begin
                    m_valid_d = 1'b1;
                    m_size_d  = {4'd0, pad_bits};
                    m_data_d  = 64'd0;
                end
                state_d = S_TRL;
            end
            S_TRL: begin
                if (trl_valid) begin
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_size_d  = 7'd64;
                    m_data_d  = {trl_isize, trl_crc};
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A 64-bit beat leaves the phase unchanged, so only the low three size bits matter.
        if (m_valid_d) begin
            phase_d = phase_q + m_size_d[2:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_size_q  <= 7'd0;
            m_data_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_size_q  <= m_size_d;
            m_data_q  <= m_data_d;
        end
    end

    assign code_ready = (state_q == S_CODE);
    assign trl_ready  = (state_q == S_TRL);
    assign busy       = busy_q;
    assign done       = done_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_size     = m_size_q;
    assign m_data     = m_data_q;

endmodule

// File: doc/gzip_stream_sequencer.md
Name: gzip_stream_sequencer

Overview:
- Sole driver of the word_merge64 bit packer in the GZIP compressor.
- For each member, sequences onto the packer's input:
  - the fixed 10-byte GZIP header;
  - the 3-bit DEFLATE block header (BFINAL=1, BTYPE=01 fixed Huffman);
  - the Huffman code stream from the encoder;
  - the end-of-block code;
  - zero padding to a byte boundary;
  - the CRC32/ISIZE trailer, flagged last.
- Tracks the bit phase so the packer always receives clean, correctly sized fields.

Parameters:
CODE_W, 32, width of encoder code bus; max code size CODE_W-1 (31 covers fixed-Huffman length+extra+dist+extra).
OS_BYTE, 8'hFF, GZIP OS header byte.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin one GZIP member; sampled only in IDLE
busy  out  1  member in progress
done  out  1  one-cycle pulse, coincident with trailer beat
code_valid  in  1  encoder code available
code_ready  out  1  sequencer accepts code this cycle
code_data  in  CODE_W  code bits, LSB first; bits at/above code_size are don't-care
code_size  in  6  number of valid bits, 0..CODE_W-1
code_last  in  1  final code of member (qualified by code_valid)
trl_valid  in  1  CRC/ISIZE available
trl_ready  out  1  trailer accepted this cycle
trl_crc  in  32  CRC32 of uncompressed data
trl_isize  in  32  uncompressed length mod 2^32
m_valid  out  1  to word_merge64 in_valid
m_last  out  1  to word_merge64 in_last
m_size  out  7  to word_merge64 in_size (1..64)
m_data  out  64  to word_merge64 in_data; bits at/above m_size forced 0

Behaviour:
- Reset (sync):
  - state=IDLE, bit phase=0.
  - All outputs 0: m_valid, m_last, m_size, m_data, busy, done, code_ready, trl_ready.
  - Reset mid-member aborts immediately; there is no partial flush.
- m_* are registered. A beat decided at edge k is presented in cycle k+1.
- Packer has no backpressure. The sequencer never stalls output once a beat is decided; m_valid may be high on consecutive cycles.
- States: IDLE, HDR0, HDR1, BHDR, CODE, EOB, PAD, TRL.
  - IDLE: start=1 -> HDR0, busy=1 next cycle. start in any other state is ignored.
  - HDR0: emit data=64'h0000_0000_0008_8B1F, size 64 (bytes 1F 8B 08 00, MTIME 0). -> HDR1.
  - HDR1: emit data={OS_BYTE,8'h00}, size 16 (XFL=0, OS). -> BHDR.
  - BHDR: emit data=3'b011, size 3. -> CODE.
  - CODE:
    - code_ready=1 (combinational on state).
    - On code_valid&&code_ready, emit code_data masked to code_size, size code_size.
    - code_size=0: consumed, no beat emitted.
    - code_last on the accepted code -> EOB.
  - EOB: emit 7'b0000000, size 7 (fixed code 256). -> PAD.
  - PAD:
    - pad=(8-phase)&7.
    - pad!=0: emit zeros of size pad.
    - pad=0: no beat.
    - -> TRL.
  - TRL:
    - trl_ready=1.
    - On trl_valid, emit {trl_isize,trl_crc}, size 64, m_last=1, done=1 in the same cycle.
    - -> IDLE; busy falls the cycle after done.
- Bit phase: 3-bit counter, phase += size mod 8 for every emitted beat. Phase is 3 after BHDR.
- Timing: start at edge k -> HDR0 beat at k+1, HDR1 at k+2, BHDR at k+3. code_ready first high in cycle k+3.
- Gaps in code_valid produce gaps in m_valid. Any idle cycles in EOB/PAD/TRL (waiting on trl_valid) hold m_valid=0.
- m_last is asserted only on the trailer beat.

Test Plan:
- Header: reset, start pulse -> three consecutive beats:
  - 0000_0000_0008_8B1F/64
  - FF00/16
  - 3/3
  - m_last=0, busy=1.
- Codes:
  - Stimulus: codes (0x71,8), (0x1A3,9), (0x8F,8, last); all upper data bits set to 1.
  - Response: beats carry masked values 0x71, 0x1A3, 0x8F, then EOB 0/7.
  - Phase 35 mod 8 = 3 -> pad beat 0/5.
- Trailer:
  - Stimulus: trl_valid delayed 4 cycles, crc=CBF43926, isize=9.
  - Response: m_valid=0 while waiting, then one beat 0000_0009_CBF4_3926/64 with m_last=1 and done=1. busy=0 the next cycle.
- Empty member:
  - Stimulus: a single code_valid with size 0, code_last.
  - Response: no code beat, EOB 0/7, pad 0/6, then trailer.
- Backpressure/ignore:
  - code_valid held high before BHDR -> code_ready=0 there and no code accepted early.
  - start pulsed during CODE -> ignored.
- Abort: reset asserted in CODE -> all outputs 0 the next cycle. A following start produces a clean HDR0 with phase restarted at 0.
